// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: bus width, output-port FIFO depth and the
// output-port FSM state type.
package arch_defs_pkg;

   localparam int DATA_WIDTH    = 8;
   localparam int OUTPORT_DEPTH = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } outport_state_t;

endpackage

// File: rtl/output_port_ctrl_if.sv
// Valid/ready handshake between the output port controller (master) and the
// external output peripheral (slave).
interface output_port_ctrl_if #(
   parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
);

   logic [DATA_WIDTH-1:0] periph_data;
   logic                  periph_valid;
   logic                  periph_ready;

   modport master (
      output periph_data,
      output periph_valid,
      input  periph_ready
   );

   modport slave (
      input  periph_data,
      input  periph_valid,
      output periph_ready
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head and an occupancy count.
// push while full and pop while empty are ignored.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_WIDTH-1:0]   din,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic [$clog2(DEPTH):0]  count
);
   import arch_defs_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q;
   logic [AW-1:0]         rd_ptr_q;
   logic [AW:0]           count_q;
   logic                  do_push;
   logic                  do_pop;

   always_comb begin
      do_push = push && (count_q != (AW+1)'(DEPTH));
      do_pop  = pop && (count_q != '0);
   end

   // storage carries no reset; only pointers and count define its contents
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/output_port_ctrl.sv
// OUTA write sequencer: FIFO-buffered, valid/ready delivery to a slow output
// peripheral. OUTPORT_TIMEOUT_EN adds a handshake timeout and sticky flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | nothing presented, periph_valid = 0
// PRESENT | holding register valid on periph_data, waiting for ready
module output_port_ctrl #(
   parameter int DATA_WIDTH     = arch_defs_pkg::DATA_WIDTH,
   parameter int DEPTH          = arch_defs_pkg::OUTPORT_DEPTH
`ifdef OUTPORT_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_out,
   input  logic [DATA_WIDTH-1:0]   bus_in,
   output logic                    stall,
   output_port_ctrl_if.master      periph,
   output logic [DATA_WIDTH-1:0]   out_val,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow
`ifdef OUTPORT_TIMEOUT_EN
   ,
   output logic                    timeout
`endif
);
   import arch_defs_pkg::*;

   localparam int LVL_W = $clog2(DEPTH) + 1;

   outport_state_t        state_q;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] hold_q;
   logic [DATA_WIDTH-1:0] out_val_q;
   logic                  overflow_q;

   logic [DATA_WIDTH-1:0] fifo_dout;
   logic [LVL_W-1:0]      fifo_count;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  handshake;
   logic                  expire;
   logic                  done;
   logic                  bypass;
   logic                  push;
   logic                  pop;

`ifdef OUTPORT_TIMEOUT_EN
   logic [7:0]            wait_q;
   logic                  timeout_q;
`endif

   always_comb begin
      fifo_empty = (fifo_count == '0);
      fifo_full  = (fifo_count == LVL_W'(DEPTH));
      handshake  = valid_q && periph.periph_ready;
`ifdef OUTPORT_TIMEOUT_EN
      expire     = valid_q && !periph.periph_ready
                   && (wait_q == 8'(TIMEOUT_CYCLES - 1));
`else
      expire     = 1'b0;
`endif
      done       = handshake || expire;
      // bypass only when nothing is queued, so a new word never overtakes
      bypass     = (state_q == IDLE) && fifo_empty && load_out;
      push       = load_out && !fifo_full && !bypass;
      pop        = !fifo_empty && ((state_q == IDLE) || done);
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus_in),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         hold_q     <= '0;
         out_val_q  <= '0;
         overflow_q <= 1'b0;
`ifdef OUTPORT_TIMEOUT_EN
         wait_q     <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         // full check uses the pre-edge count, so a same-cycle pop does not save the write
         if (load_out && fifo_full) begin
            overflow_q <= 1'b1;
         end
         if (handshake) begin
            out_val_q <= hold_q;
         end
         case (state_q)
            IDLE: begin
               if (pop) begin
                  hold_q  <= fifo_dout;
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end else if (bypass) begin
                  hold_q  <= bus_in;
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end
            end
            PRESENT: begin
               if (done) begin
                  if (pop) begin
                     hold_q <= fifo_dout;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
         endcase
`ifdef OUTPORT_TIMEOUT_EN
         if (state_q == PRESENT && !done && !periph.periph_ready) begin
            wait_q <= wait_q + 1'b1;
         end else begin
            wait_q <= '0;
         end
         if (expire) begin
            timeout_q <= 1'b1;
         end
`endif
      end
   end

   assign stall               = fifo_full;
   assign level               = fifo_count;
   assign periph.periph_data  = hold_q;
   assign periph.periph_valid = valid_q;
   assign out_val             = out_val_q;
   assign overflow            = overflow_q;
`ifdef OUTPORT_TIMEOUT_EN
   assign timeout             = timeout_q;
`endif

endmodule

// File: tb/tb_output_port_ctrl.sv
// Directed bench for output_port_ctrl with a delivery scoreboard; the
// OUTPORT_TIMEOUT_EN section runs only when that macro is defined.
module tb_output_port_ctrl;

   logic       clk;
   logic       reset;
   logic       load_out;
   logic [7:0] bus_in;
   logic       stall;
   logic [7:0] out_val;
   logic [2:0] level;
   logic       overflow;
`ifdef OUTPORT_TIMEOUT_EN
   logic       timeout;
`endif

   int checks   = 0;
   int failures = 0;
   logic [7:0] sb [$];
   logic [7:0] discarded;

   output_port_ctrl_if #(.DATA_WIDTH(8)) pif ();

   output_port_ctrl #(
      .DATA_WIDTH     (8),
      .DEPTH          (4)
`ifdef OUTPORT_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (8)
`endif
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .load_out (load_out),
      .bus_in   (bus_in),
      .stall    (stall),
      .periph   (pif.master),
      .out_val  (out_val),
      .level    (level),
      .overflow (overflow)
`ifdef OUTPORT_TIMEOUT_EN
      ,
      .timeout  (timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [7:0] d, input bit track);
      load_out = 1'b1;
      bus_in   = d;
      if (track) sb.push_back(d);
      tick();
      load_out = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},    32'(pif.periph_valid), 32'h0);
      check({tag, "_data"},     32'(pif.periph_data),  32'h0);
      check({tag, "_out_val"},  32'(out_val),          32'h0);
      check({tag, "_level"},    32'(level),            32'h0);
      check({tag, "_stall"},    32'(stall),            32'h0);
      check({tag, "_overflow"}, 32'(overflow),         32'h0);
   endtask

   // handshake seen between edges completes at the next rising edge
   always @(negedge clk) begin
      if (!reset && pif.periph_valid && pif.periph_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_delivery", 32'(pif.periph_data), 32'hFFFF_FFFF);
         end else begin
            check("delivery_order", 32'(pif.periph_data), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      reset            = 1'b1;
      load_out         = 1'b0;
      bus_in           = 8'h00;
      pif.periph_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check_all_zero("reset");

      // single bypass write with ready tied high
      pif.periph_ready = 1'b1;
      write_word(8'h09, 1'b1);
      check("t1_valid", 32'(pif.periph_valid), 32'h1);
      check("t1_data",  32'(pif.periph_data),  32'h09);
      tick();
      check("t1_out_val", 32'(out_val),          32'h09);
      check("t1_idle",    32'(pif.periph_valid), 32'h0);
      check("t1_level",   32'(level),            32'h0);

      // fill to full with ready low, then overflow
      pif.periph_ready = 1'b0;
      for (int i = 1; i <= 5; i++) write_word(8'(i), 1'b1);
      check("t2_level_full", 32'(level),           32'h4);
      check("t2_stall",      32'(stall),           32'h1);
      check("t2_hold",       32'(pif.periph_data), 32'h01);
      check("t2_no_ovf_yet", 32'(overflow),        32'h0);
      write_word(8'hAA, 1'b0);
      check("t2_overflow",   32'(overflow),        32'h1);
      check("t2_level_drop", 32'(level),           32'h4);
      pif.periph_ready = 1'b1;
      tick();
      check("t2_stall_clear", 32'(stall),           32'h0);
      check("t2_level_3",     32'(level),           32'h3);
      check("t2_out_val_1",   32'(out_val),         32'h01);
      check("t2_next_word",   32'(pif.periph_data), 32'h02);
      repeat (4) tick();
      check("t2_drained_valid", 32'(pif.periph_valid), 32'h0);
      check("t2_drained_val",   32'(out_val),          32'h05);

      // full FIFO: write and handshake in the same cycle drops the write
      pif.periph_ready = 1'b0;
      for (int i = 0; i < 5; i++) write_word(8'h11 + 8'(i), 1'b1);
      check("t3_full", 32'(stall), 32'h1);
      load_out         = 1'b1;
      bus_in           = 8'h77;
      pif.periph_ready = 1'b1;
      tick();
      load_out         = 1'b0;
      pif.periph_ready = 1'b0;
      check("t3_level",    32'(level),           32'h3);
      check("t3_overflow", 32'(overflow),        32'h1);
      check("t3_head",     32'(pif.periph_data), 32'h12);

      // level 2, then push and handshake together
      pif.periph_ready = 1'b1;
      tick();
      pif.periph_ready = 1'b0;
      check("t4_level_2", 32'(level), 32'h2);
      load_out         = 1'b1;
      bus_in           = 8'h21;
      sb.push_back(8'h21);
      pif.periph_ready = 1'b1;
      tick();
      load_out         = 1'b0;
      pif.periph_ready = 1'b0;
      check("t4_level_kept", 32'(level),           32'h2);
      check("t4_head",       32'(pif.periph_data), 32'h14);
      pif.periph_ready = 1'b1;
      repeat (3) tick();
      check("t4_idle",    32'(pif.periph_valid), 32'h0);
      check("t4_out_val", 32'(out_val),          32'h21);
      check("t4_level_0", 32'(level),            32'h0);

      // reset in mid-handshake drops everything pending
      pif.periph_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word(8'h31 + 8'(i), 1'b0);
      check("t5_level_3", 32'(level),            32'h3);
      check("t5_present", 32'(pif.periph_valid), 32'h1);
      reset = 1'b1;
      tick();
      check_all_zero("t5_reset");
      reset            = 1'b0;
      pif.periph_ready = 1'b1;
      write_word(8'h42, 1'b1);
      check("t5_valid", 32'(pif.periph_valid), 32'h1);
      check("t5_data",  32'(pif.periph_data),  32'h42);
      tick();
      check("t5_out_val", 32'(out_val), 32'h42);
      pif.periph_ready = 1'b0;

`ifdef OUTPORT_TIMEOUT_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("to_reset_flag", 32'(timeout), 32'h0);
      write_word(8'h10, 1'b1);
      write_word(8'h20, 1'b1);
      repeat (6) tick();
      check("to_still_held", 32'(pif.periph_data), 32'h10);
      check("to_not_yet",    32'(timeout),         32'h0);
      tick();
      check("to_next_word", 32'(pif.periph_data),  32'h20);
      check("to_flag",      32'(timeout),          32'h1);
      check("to_out_val",   32'(out_val),          32'h00);
      check("to_valid",     32'(pif.periph_valid), 32'h1);
      discarded = sb.pop_front();
      pif.periph_ready = 1'b1;
      tick();
      pif.periph_ready = 1'b0;
      check("to_deliver", 32'(out_val), 32'(8'h20));
`endif

      tick();
      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
